// File: rtl/exp4_unidade_controle.sv
// -----------------------------------------------------------------------------
// exp4_unidade_controle
//
// Control unit for a 16-play memory game. This is a Moore FSM: every output
// depends only on the current state. The outputs are registered from the
// next-state decode, so they always match the state register and they clear
// together with it on reset.
//
// Ports
//   clock            in   system clock, rising-edge active
//   reset            in   asynchronous active-high reset (forces inicial)
//   iniciar          in   start/restart a round (used in inicial and end states)
//   jogada_feita     in   one-cycle pulse on a new key press
//   igual            in   ROM data equals the registered play
//   fimC             in   address counter is at its last position
//   controle_timeout in   play-timeout counter reached its end
//   zeraC            out  clear address counter, edge detector, timeout counter
//   contaC           out  advance address counter, clear timeout counter
//   contaT           out  enable timeout counter
//   zeraR            out  clear play register and timeout counter
//   registraR        out  load play register
//   pronto           out  round finished
//   acertou          out  all plays matched
//   errou            out  a play mismatched
//   timeout          out  player ran out of time
//   db_estado [3:0]  out  current state code for the debug display
// -----------------------------------------------------------------------------
module exp4_unidade_controle (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada_feita,
  input  logic       igual,
  input  logic       fimC,
  input  logic       controle_timeout,
  output logic       zeraC,
  output logic       contaC,
  output logic       contaT,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    S_INICIAL     = 4'h0,
    S_PREPARACAO  = 4'h1,
    S_ESPERA      = 4'h2,
    S_REGISTRA    = 4'h4,
    S_COMPARACAO  = 4'h5,
    S_PROXIMO     = 4'h6,
    S_FIM_ACERTOU = 4'hA,
    S_FIM_TIMEOUT = 4'hD,
    S_FIM_ERROU   = 4'hE
  } state_t;

  // Output bundle bit order:
  // {zeraC, contaC, contaT, zeraR, registraR, pronto, acertou, errou, timeout}
  function automatic logic [8:0] decode_outputs(input state_t s);
    logic [8:0] o;
    o = 9'b0_0000_0000;
    case (s)
      S_INICIAL:     o = 9'b0_0000_0000;
      S_PREPARACAO:  o = 9'b1_0010_0000;
      S_ESPERA:      o = 9'b0_0100_0000;
      S_REGISTRA:    o = 9'b0_0001_0000;
      S_COMPARACAO:  o = 9'b0_0000_0000;
      S_PROXIMO:     o = 9'b0_1000_0000;
      S_FIM_ACERTOU: o = 9'b0_0000_1100;
      S_FIM_ERROU:   o = 9'b0_0000_1010;
      S_FIM_TIMEOUT: o = 9'b0_0000_1001;
      default:       o = 9'b0_0000_0000;
    endcase
    return o;
  endfunction

  state_t     state_q;
  state_t     state_d;
  logic [8:0] outs_q;
  logic [8:0] outs_d;

  // Next-state logic and decode of the outputs the next state will drive.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INICIAL: begin
        if (iniciar) state_d = S_PREPARACAO;
        else         state_d = S_INICIAL;
      end
      S_PREPARACAO: state_d = S_ESPERA;
      S_ESPERA: begin
        // A play arriving together with the timeout still counts.
        if (jogada_feita)          state_d = S_REGISTRA;
        else if (controle_timeout) state_d = S_FIM_TIMEOUT;
        else                       state_d = S_ESPERA;
      end
      // One cycle for the play register and synchronous ROM to settle.
      S_REGISTRA: state_d = S_COMPARACAO;
      S_COMPARACAO: begin
        if (!igual)    state_d = S_FIM_ERROU;
        else if (fimC) state_d = S_FIM_ACERTOU;
        else           state_d = S_PROXIMO;
      end
      S_PROXIMO: state_d = S_ESPERA;
      S_FIM_ACERTOU, S_FIM_ERROU, S_FIM_TIMEOUT: begin
        if (iniciar) state_d = S_PREPARACAO;
        else         state_d = state_q;
      end
      default: state_d = S_INICIAL;
    endcase
    outs_d = decode_outputs(state_d);
  end

  // State register and registered outputs; reset clears both at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_INICIAL;
      outs_q  <= 9'b0_0000_0000;
    end else begin
      state_q <= state_d;
      outs_q  <= outs_d;
    end
  end

  assign zeraC     = outs_q[8];
  assign contaC    = outs_q[7];
  assign contaT    = outs_q[6];
  assign zeraR     = outs_q[5];
  assign registraR = outs_q[4];
  assign pronto    = outs_q[3];
  assign acertou   = outs_q[2];
  assign errou     = outs_q[1];
  assign timeout   = outs_q[0];
  assign db_estado = state_q;

endmodule
